// File: rtl/wave_display_pkg.sv
// Shared types and constants for the multi-voice waveform renderer.
package wave_display_pkg;

    localparam int DISP_BITS = 8;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t WHITE = rgb_t'(24'hFFFFFF);
    localparam rgb_t BLACK = rgb_t'(24'h000000);

    // Voice colours, indexed by voice number; voice 0 has the highest priority.
    localparam rgb_t PALETTE [0:9] = '{
        rgb_t'(24'hFF0000),
        rgb_t'(24'h00FF00),
        rgb_t'(24'h0000FF),
        rgb_t'(24'hFFFF00),
        rgb_t'(24'h00FFFF),
        rgb_t'(24'hFF00FF),
        rgb_t'(24'hFFA500),
        rgb_t'(24'h800080),
        rgb_t'(24'hFFC0CB),
        rgb_t'(24'h808080)
    };

endpackage

// File: rtl/wave_trace_cmp.sv
// One trace channel: remembers the previous sample's row and reports whether
// the current raster row lies on the vertical segment joining it to this sample.
module wave_trace_cmp
    import wave_display_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DISP_BITS-1:0] i_sample,
    input  logic [7:0]           i_ry,
    input  logic                 i_in_window,
    input  logic                 i_first_col,
    input  logic                 i_new_sample,
    output logic                 o_hit
);

    logic [7:0] r_prev;
    logic [7:0] w_row;
    logic [7:0] w_prev_eff;
    logic [7:0] w_lo;
    logic [7:0] w_hi;

    // Segment endpoints; the first column of a line never joins back to the previous line.
    always_comb begin
        w_row      = 8'hFF - i_sample;
        w_prev_eff = i_first_col ? w_row : r_prev;
        if (w_row < w_prev_eff) begin
            w_lo = w_row;
            w_hi = w_prev_eff;
        end else begin
            w_lo = w_prev_eff;
            w_hi = w_row;
        end
        o_hit = (i_ry >= w_lo) && (i_ry <= w_hi);
    end

    // Capture this sample's row on the first pixel of each sample inside the window.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev <= '0;
        end else if (i_new_sample && i_in_window) begin
            r_prev <= w_row;
        end
    end

endmodule

// File: rtl/wave_display_multi.sv
// Renders the mixed waveform in white plus per-voice traces in palette colours
// into the raster window; two-clock latency from x/y/valid to pixel output.
module wave_display_multi
    import wave_display_pkg::*;
#(
    parameter int N_VOICES = 3,
    parameter int SAMPLE_W = 8,
    parameter int ADDR_W   = 9,
    parameter int X_OFFSET = 512,
    parameter int Y_OFFSET = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid,
    input  logic                         read_index,
    input  logic [10:0]                  x,
    input  logic [9:0]                   y,
    output logic [ADDR_W-1:0]            read_address,
    input  logic [SAMPLE_W-1:0]          read_value,
    input  logic [N_VOICES*SAMPLE_W-1:0] note_values,
    input  logic [N_VOICES-1:0]          voice_enable,
    output logic                         valid_pixel,
    output logic [7:0]                   r,
    output logic [7:0]                   g,
    output logic [7:0]                   b
);

    logic                r_latched_idx;
    logic [7:0]          r_s1_ry;
    logic                r_s1_in_win;
    logic                r_s1_valid;
    logic                r_s1_first;
    logic                r_s1_new;

    logic [31:0]         w_wx_full;
    logic [31:0]         w_ry_full;
    logic                w_in_x;
    logic                w_in_y;
    logic [ADDR_W-1:0]   w_wx;
    logic                w_mix_hit;
    logic [N_VOICES-1:0] w_voice_hit;
    rgb_t                w_colour;

    // Window-relative coordinates with explicit range checks so nothing wraps in.
    always_comb begin
        w_wx_full    = 32'(x) - 32'(X_OFFSET);
        w_ry_full    = 32'(y) - 32'(Y_OFFSET);
        w_in_x       = (32'(x) >= 32'(X_OFFSET)) && (w_wx_full < 32'(1 << ADDR_W));
        w_in_y       = (32'(y) >= 32'(Y_OFFSET)) && (w_ry_full < 32'd256);
        w_wx         = w_wx_full[ADDR_W-1:0];
        read_address = {r_latched_idx, w_wx[ADDR_W-1:1]};
    end

    // Buffer select is only taken at the top-left pixel so a frame never mixes buffers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_latched_idx <= 1'b0;
        end else if (x == 11'd0 && y == 10'd0) begin
            r_latched_idx <= read_index;
        end
    end

    // Sideband travels alongside the RAM read so it lines up with the returned data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_ry     <= '0;
            r_s1_in_win <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_new    <= 1'b0;
        end else begin
            r_s1_ry     <= w_ry_full[7:0];
            r_s1_in_win <= w_in_x && w_in_y;
            r_s1_valid  <= valid;
            r_s1_first  <= (w_wx == '0);
            r_s1_new    <= ~w_wx[0];
        end
    end

    wave_trace_cmp u_mix_cmp (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_sample     (read_value[SAMPLE_W-1 -: DISP_BITS]),
        .i_ry         (r_s1_ry),
        .i_in_window  (r_s1_in_win),
        .i_first_col  (r_s1_first),
        .i_new_sample (r_s1_new),
        .o_hit        (w_mix_hit)
    );

    for (genvar k = 0; k < N_VOICES; k++) begin : g_voice
        wave_trace_cmp u_voice_cmp (
            .i_clk        (clk),
            .i_reset      (reset),
            .i_sample     (note_values[k*SAMPLE_W + SAMPLE_W - 1 -: DISP_BITS]),
            .i_ry         (r_s1_ry),
            .i_in_window  (r_s1_in_win),
            .i_first_col  (r_s1_first),
            .i_new_sample (r_s1_new),
            .o_hit        (w_voice_hit[k])
        );
    end

    // Mix wins over every voice; among voices the lowest enabled index wins.
    always_comb begin
        w_colour = BLACK;
        if (r_s1_in_win) begin
            if (w_mix_hit) begin
                w_colour = WHITE;
            end else begin
                for (int k = N_VOICES - 1; k >= 0; k--) begin
                    if (w_voice_hit[k] && voice_enable[k]) begin
                        w_colour = PALETTE[k];
                    end
                end
            end
        end
    end

    // Output register; pixels without a valid strobe are forced to black.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_pixel <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
        end else begin
            valid_pixel <= r_s1_valid;
            if (r_s1_valid) begin
                {r, g, b} <= w_colour;
            end else begin
                {r, g, b} <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wave_display_multi.sv
// Randomised and directed raster scans of wave_display_multi checked against a
// pixel-level reference model working from the sample memories directly.
module tb_wave_display_multi;

    localparam int NV = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic        read_index;
    logic [10:0] x;
    logic [9:0]  y;
    logic [8:0]  read_address;
    logic [7:0]  read_value;
    logic [23:0] note_values;
    logic [2:0]  voice_enable;
    logic        valid_pixel;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;

    logic [7:0]  mixMem [512];
    logic [7:0]  voiceMem [NV][512];

    int          assertCount = 0;
    int          failCount   = 0;
    int          modelIdx    = 0;
    logic        riCur       = 1'b0;
    logic [24:0] expQ [$];

    wave_display_multi #(
        .N_VOICES (NV),
        .SAMPLE_W (8),
        .ADDR_W   (9),
        .X_OFFSET (512),
        .Y_OFFSET (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid        (valid),
        .read_index   (read_index),
        .x            (x),
        .y            (y),
        .read_address (read_address),
        .read_value   (read_value),
        .note_values  (note_values),
        .voice_enable (voice_enable),
        .valid_pixel  (valid_pixel),
        .r            (r),
        .g            (g),
        .b            (b)
    );

    // Free-running pixel clock.
    always #5 clk = ~clk;

    // Sample RAM with one-cycle synchronous read, mix and voices at the same address.
    always @(posedge clk) begin
        read_value <= mixMem[read_address];
        for (int k = 0; k < NV; k++) begin
            note_values[k*8 +: 8] <= voiceMem[k][read_address];
        end
    end

    function automatic logic [23:0] palColour(input int k);
        case (k)
            0: return 24'hFF0000;
            1: return 24'h00FF00;
            2: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // A trace covers the rows between its previous sample and the current one,
    // but only on the first pixel of a sample; the second pixel draws just its own row.
    function automatic bit chanHit(input int cur, input int prevSample, input int wx, input int ry);
        int rowCur;
        int rowPrev;
        rowCur  = 255 - cur;
        rowPrev = (wx > 0 && (wx % 2) == 0) ? 255 - prevSample : rowCur;
        if (rowCur <= rowPrev) return (ry >= rowCur && ry <= rowPrev);
        return (ry >= rowPrev && ry <= rowCur);
    endfunction

    function automatic logic [24:0] modelPixel(input int px, input int py, input logic pv, input int idx);
        int wx;
        int s;
        int base;
        if (!pv) return 25'd0;
        if (px < 512 || px >= 1024 || py >= 256) return {1'b1, 24'h000000};
        wx   = px - 512;
        s    = wx / 2;
        base = idx * 256;
        if (chanHit(int'(mixMem[base + s]), (s > 0) ? int'(mixMem[base + s - 1]) : 0, wx, py))
            return {1'b1, 24'hFFFFFF};
        for (int k = 0; k < NV; k++) begin
            if (voice_enable[k] &&
                chanHit(int'(voiceMem[k][base + s]), (s > 0) ? int'(voiceMem[k][base + s - 1]) : 0, wx, py))
                return {1'b1, palColour(k)};
        end
        return {1'b1, 24'h000000};
    endfunction

    task automatic checkOutput(input string tag, input logic [24:0] expected);
        assertCount++;
        assert ({valid_pixel, r, g, b} === expected)
        else begin
            failCount++;
            $error("FAIL %s: observed {valid,rgb}=%h expected %h", tag, {valid_pixel, r, g, b}, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic [10:0] px,
                                 input logic [9:0] py, input logic ri);
        logic [8:0] expAddr;
        reset      = rst;
        valid      = v;
        x          = px;
        y          = py;
        read_index = ri;
        #1;
        if (!rst && px >= 11'd512 && px < 11'd1024) begin
            expAddr = 9'(modelIdx * 256 + (int'(px) - 512) / 2);
            assertCount++;
            assert (read_address === expAddr)
            else begin
                failCount++;
                $error("FAIL read_address x=%0d y=%0d: observed %h expected %h", px, py, read_address, expAddr);
            end
        end
        if (rst) expQ.delete();
        else expQ.push_back(modelPixel(int'(px), int'(py), v, modelIdx));
        if (rst) modelIdx = 0;
        else if (px == 11'd0 && py == 10'd0) modelIdx = int'(ri);
        @(posedge clk);
        #1;
        if (rst) begin
            checkOutput("reset_out", 25'd0);
            expQ.push_back(25'd0);
        end else if (expQ.size() > 1) begin
            checkOutput("pixel", expQ.pop_front());
        end
    endtask

    task automatic scanLine(input int py, input int xs, input int xe, input bit randValid, input int dropX);
        for (int px = xs; px <= xe; px++) begin
            logic v;
            v = randValid ? ($urandom_range(0, 7) != 0) : 1'b1;
            if (px == dropX) v = 1'b0;
            applyStimulus(1'b0, v, 11'(px), 10'(py), riCur);
        end
        applyStimulus(1'b0, 1'b0, 11'd2000, 10'd1000, riCur);
    endtask

    task automatic frameStart(input logic ri);
        riCur = ri;
        applyStimulus(1'b0, 1'b1, 11'd0, 10'd0, ri);
        applyStimulus(1'b0, 1'b0, 11'd2000, 10'd1000, ri);
    endtask

    task automatic randomFill();
        for (int i = 0; i < 512; i++) begin
            mixMem[i] = 8'($urandom);
            for (int k = 0; k < NV; k++) voiceMem[k][i] = 8'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mixMem[i] = 8'h00;
            for (int k = 0; k < NV; k++) voiceMem[k][i] = 8'h00;
        end
        voice_enable = 3'b000;
        reset = 1'b1; valid = 1'b0; x = '0; y = '0; read_index = 1'b0;

        $display("[TB] reset held four cycles with valid high");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b1, 11'($urandom_range(0, 2047)), 10'($urandom_range(0, 1023)), 1'b0);

        frameStart(1'b0);

        $display("[TB] flat mix at 0x80");
        for (int i = 0; i < 256; i++) mixMem[i] = 8'h80;
        scanLine(127, 508, 604, 1'b0, -1);
        scanLine(126, 508, 604, 1'b0, -1);
        scanLine(128, 508, 604, 1'b0, -1);

        $display("[TB] mix step between samples 10 and 11");
        mixMem[10] = 8'h10;
        mixMem[11] = 8'hF0;
        scanLine(14, 508, 540, 1'b0, -1);
        scanLine(15, 508, 540, 1'b0, -1);
        scanLine(100, 508, 540, 1'b0, -1);
        scanLine(239, 508, 540, 1'b0, -1);
        scanLine(240, 508, 540, 1'b0, -1);

        $display("[TB] voice priority");
        for (int i = 0; i < 256; i++) begin
            mixMem[i]      = 8'h40;
            voiceMem[0][i] = 8'h40;
            voiceMem[1][i] = 8'h40;
        end
        voice_enable = 3'b011;
        scanLine(191, 508, 540, 1'b0, -1);
        for (int i = 0; i < 256; i++) mixMem[i] = 8'h00;
        scanLine(191, 508, 540, 1'b0, -1);
        scanLine(255, 508, 540, 1'b0, -1);

        $display("[TB] valid dropped on a hit pixel");
        scanLine(191, 508, 630, 1'b0, 620);

        $display("[TB] buffer select only at frame start");
        randomFill();
        riCur = 1'b1;
        applyStimulus(1'b0, 1'b1, 11'd700, 10'd100, 1'b1);
        scanLine(int'($urandom_range(0, 255)), 508, 560, 1'b1, -1);
        frameStart(1'b1);
        riCur = 1'b0;
        scanLine(int'($urandom_range(0, 255)), 508, 560, 1'b1, -1);

        $display("[TB] random lines");
        for (int n = 0; n < 12; n++) begin
            voice_enable = 3'($urandom);
            riCur        = 1'($urandom);
            scanLine(int'($urandom_range(0, 300)), int'($urandom_range(500, 511)),
                     int'($urandom_range(520, 1040)), 1'b1, -1);
        end

        $display("[TB] reset in mid frame");
        riCur = 1'b1;
        applyStimulus(1'b1, 1'b1, 11'd900, 10'd50, riCur);
        scanLine(50, 508, 600, 1'b1, -1);
        frameStart(1'b1);
        scanLine(int'($urandom_range(0, 255)), 505, 1030, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/wave_display_multi.md
Name: wave_display_multi

Overview:
- Parametrised successor to the single-trace waveform renderer.
- Draws the mixed output plus up to N_VOICES per-voice traces, each in its own palette colour, into the raster driven by the DVI controller's x/y.
- Reads a double-buffered sample RAM and N_VOICES voice sample buses.
- Joins consecutive samples with vertical segments, so traces stay continuous.
- Latches the buffer select only at frame start, so a frame is never torn.

Parameters:
- N_VOICES, 3: number of per-voice traces (1..10).
- SAMPLE_W, 8: sample width; the top 8 bits are displayed.
- ADDR_W, 9: RAM address width; MSB is buffer select, giving 2^(ADDR_W-1) samples per buffer.
- X_OFFSET, 512: first pixel column of the trace window.
- Y_OFFSET, 0: first pixel row of the trace window.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- valid, in, 1: raster pixel valid from the DVI controller.
- read_index, in, 1: buffer the audio side is not writing.
- x, in, 11: current pixel column.
- y, in, 10: current pixel row.
- read_address, out, ADDR_W: sample RAM address; RAM has 1-cycle synchronous read.
- read_value, in, SAMPLE_W: mixed sample from RAM.
- note_values, in, N_VOICES*SAMPLE_W: voice samples read at the same read_address; voice k is bits [k*SAMPLE_W +: SAMPLE_W].
- voice_enable, in, N_VOICES: per-voice trace enable.
- valid_pixel, out, 1: valid, delayed to align with r/g/b.
- r, out, 8: red pixel data.
- g, out, 8: green pixel data.
- b, out, 8: blue pixel data.

Behaviour:
- Reset: r=g=b=0, valid_pixel=0, latched index=0, all prev-sample registers=0, pipeline valid bits=0. read_address = {0, 0...}.
- Index latch: latched_idx <= read_index when x==0 and y==0 (same cycle as the x/y inputs). It is held for the rest of the frame.
- Window:
  - wx = x - X_OFFSET; in_x when 0 <= wx < 2^ADDR_W, i.e. each sample is 2 pixels wide.
  - ry = y - Y_OFFSET; in_y when 0 <= ry < 256.
  - All arithmetic is unsigned with explicit range checks; there is no wrap into the window.
- Stage 0 (combinational address, registered sideband):
  - read_address = {latched_idx, wx[ADDR_W-1:1]}, driven even outside the window; value is don't-care there.
  - Register ry, in_x&&in_y, valid, first_col = (wx==0), new_sample = (wx[0]==0).
- Stage 1 (RAM data valid):
  - For each channel c (mix plus voices), cur_c = sample[SAMPLE_W-1 -: 8] and row_c = 255 - cur_c.
  - hit_c when ry lies between min(row_c, prev_c) and max(row_c, prev_c) inclusive.
  - prev_c update: when new_sample && in_window, prev_c <= row_c after compare. When first_col, the compare uses prev_c = row_c, so no segment crosses from the previous line.
- Colour priority:
  - mix hit gives white (FF,FF,FF).
  - Otherwise the lowest-index enabled voice hit gives PALETTE[k].
  - Otherwise, or outside the window, black.
  - Disabled voices never hit.
- Stage 2: r/g/b and valid_pixel are registered. Total latency from x/y/valid to r/g/b/valid_pixel is exactly 2 clocks.
- Output when valid is low: valid_pixel=0 and r/g/b forced to 0 at the output.
- Reset mid-frame: outputs are 0 on the next cycle. Rendering resumes with latched_idx=0 until the next (0,0).
- Simultaneous events: read_index changing on the (0,0) cycle is captured. Changes on any other cycle are ignored.

Decomposition:
- Package wave_display_pkg holds:
  - the 8-bit RGB struct;
  - the PALETTE[0..9] constant: red, green, blue, yellow, cyan, magenta, orange, purple, pink, grey;
  - WHITE and BLACK constants;
  - DISP_BITS=8.
- Sub-module wave_trace_cmp holds prev register, first-column and new-sample handling, and the min/max inclusive compare producing hit. It is instantiated N_VOICES+1 times.

Test Plan:
- Reset held 4 cycles, then released with valid=1 -> r,g,b=0 and valid_pixel=0 during reset; first output appears 2 clocks after the first x/y.
- Flat mix 0x80, voices 0, voice_enable=0, X_OFFSET=512 -> at x=600, only row 127 is white; x=511 is black for all rows; read_address=0x02C at x=600 with latched_idx=0.
- Mix step 0x10 to 0xF0 between samples 10 and 11 (x=532,534) -> column 534 is white for rows 15..239 inclusive; column 533 is white only at row 239.
- Voice0 = mix = 0x40, voice1 = 0x40, voice_enable=3'b011 -> row 191 is white (mix wins). With mix moved to 0x00, row 191 shows PALETTE[0] red (voice0 beats voice1).
- read_index toggled at x=700,y=100 -> read_address MSB stays 0 until the next x=0,y=0, then becomes 1 for the whole next frame.
- valid=0 for one cycle at x=620 with a hit pixel -> 2 clocks later valid_pixel=0 and r=g=b=0; the neighbouring pixels are unaffected.
